// File: rtl/e1_tx_bd_sched_if.sv
// TX buffer-descriptor FIFO handshake bundle for the E1 TX BD scheduler.
// master: the scheduler (pushes BD-In, pops BD-Out); slave: the FIFO side.
interface e1_tx_bd_sched_if #(
    parameter int unsigned MFW = 7
) ();
    localparam int unsigned DW = MFW + 2;

    // BD-In: {crc_e[1:0], mf} write port
    logic [DW-1:0]  bti_data;
    logic           bti_wren;
    logic           bti_full;

    // BD-Out: fall-through head with pop strobe
    logic [MFW-1:0] bto_data;
    logic           bto_rden;
    logic           bto_empty;

    modport master (
        output bti_data,
        output bti_wren,
        input  bti_full,
        input  bto_data,
        output bto_rden,
        input  bto_empty
    );

    modport slave (
        input  bti_data,
        input  bti_wren,
        output bti_full,
        output bto_data,
        input  bto_rden,
        output bto_empty
    );
endinterface

// File: rtl/e1_tx_bd_sched.sv
// E1 TX buffer-descriptor scheduler: feeds BD-In with consecutive multiframe
// indices up to a software limit, reaps BD-Out completions and keeps the
// submit/done pointers of a 2^MFW multiframe ring.
module e1_tx_bd_sched #(
    parameter int unsigned MFW          = 7,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_ctrl_enable,
    input  logic [MFW-1:0]      i_ctrl_base,
    input  logic [1:0]          i_ctrl_crc_e,
    input  logic [MFW-1:0]      i_sw_limit,
    input  logic                i_sw_limit_we,
    input  logic                i_err_clr,
    e1_tx_bd_sched_if.master    bd,
    output logic [MFW-1:0]      o_hw_submit,
    output logic [MFW-1:0]      o_hw_done,
    output logic [2:0]          o_inflight,
    output logic                o_busy,
    output logic                o_done_stb,
    output logic                o_err_seq,
    output logic                o_err_lim,
    output logic                o_starve
);
    localparam int unsigned DW  = MFW + 2;
    localparam int unsigned IFW = 3;
    localparam logic [IFW-1:0] MAX_IF = IFW'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_run_first;
    logic [MFW-1:0]     r_hw_submit;
    logic [MFW-1:0]     r_hw_done;
    logic [MFW-1:0]     r_limit;
    logic [IFW-1:0]     r_inflight;
    logic [DW-1:0]      r_bti_data;
    logic               r_bti_wren;
    logic               r_bto_rden;
    logic               r_busy;
    logic               r_done_stb;
    logic               r_err_seq;
    logic               r_err_lim;
    logic               r_starve;

    logic               w_submit;
    logic               w_reap;
    logic               w_seq_bad;
    logic               w_lim_bad;
    logic               w_starve;
    logic [MFW-1:0]     w_lim_dist;
    logic [MFW-1:0]     w_sub_dist;

    // Submit one BD every other cycle so bti_full has a cycle to reflect the last write
    assign w_submit = (r_state == S_RUN) && !r_bti_wren && !bd.bti_full &&
                      (r_hw_submit != r_limit) && (r_inflight < MAX_IF);

    // Reap one completion every other cycle for the same reason on the BD-Out side
    assign w_reap   = (r_state != S_IDLE) && !r_bto_rden && !bd.bto_empty;

    assign w_seq_bad = w_reap && (bd.bto_data != r_hw_done);

    // Ring distances measured from hw_done; a new limit closer than hw_submit is behind it
    assign w_lim_dist = i_sw_limit - r_hw_done;
    assign w_sub_dist = r_hw_submit - r_hw_done;
    assign w_lim_bad  = i_sw_limit_we && (w_lim_dist < w_sub_dist);

    // Nothing in flight and nothing left to submit; skipped on the first RUN cycle
    assign w_starve = (r_state == S_RUN) && !r_run_first &&
                      (r_inflight == '0) && (r_hw_submit == r_limit);

    // Scheduler state, pointers, FIFO strobes and sticky status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_run_first <= 1'b0;
            r_hw_submit <= '0;
            r_hw_done   <= '0;
            r_limit     <= '0;
            r_inflight  <= '0;
            r_bti_data  <= '0;
            r_bti_wren  <= 1'b0;
            r_bto_rden  <= 1'b0;
            r_busy      <= 1'b0;
            r_done_stb  <= 1'b0;
            r_err_seq   <= 1'b0;
            r_err_lim   <= 1'b0;
            r_starve    <= 1'b0;
        end else begin
            r_bti_wren <= w_submit;
            r_bto_rden <= w_reap;
            r_done_stb <= w_reap;

            if (w_submit) begin
                r_bti_data  <= {i_ctrl_crc_e, r_hw_submit};
                r_hw_submit <= r_hw_submit + MFW'(1);
            end

            // Completion always resyncs hw_done to the index actually returned
            if (w_reap) begin
                r_hw_done <= bd.bto_data + MFW'(1);
            end

            if (w_submit && !w_reap) begin
                r_inflight <= r_inflight + IFW'(1);
            end else if (w_reap && !w_submit && (r_inflight != '0)) begin
                r_inflight <= r_inflight - IFW'(1);
            end

            if (i_sw_limit_we) begin
                r_limit <= i_sw_limit;
            end

            r_err_seq <= w_seq_bad || (r_err_seq && !i_err_clr);
            r_err_lim <= w_lim_bad || (r_err_lim && !i_err_clr);
            r_starve  <= w_starve  || (r_starve  && !i_err_clr);

            case (r_state)
                S_IDLE: begin
                    r_run_first <= 1'b0;
                    if (i_ctrl_enable) begin
                        r_state     <= S_RUN;
                        r_run_first <= 1'b1;
                        r_hw_submit <= i_ctrl_base;
                        r_hw_done   <= i_ctrl_base;
                        r_inflight  <= '0;
                        r_busy      <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_run_first <= 1'b0;
                    if (!i_ctrl_enable) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_run_first <= 1'b0;
                    if (r_inflight == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_run_first <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bd.bti_data = r_bti_data;
    assign bd.bti_wren = r_bti_wren;
    assign bd.bto_rden = r_bto_rden;

    assign o_hw_submit = r_hw_submit;
    assign o_hw_done   = r_hw_done;
    assign o_inflight  = r_inflight;
    assign o_busy      = r_busy;
    assign o_done_stb  = r_done_stb;
    assign o_err_seq   = r_err_seq;
    assign o_err_lim   = r_err_lim;
    assign o_starve    = r_starve;

endmodule

// File: tb/tb_e1_tx_bd_sched.sv
// Directed bench for the E1 TX BD scheduler with a small BD-Out FIFO model
// and a BD-In write recorder.
module tb_e1_tx_bd_sched;
    localparam int unsigned MFW = 7;

    logic           clk = 1'b0;
    logic           rst;
    logic           ctrl_enable;
    logic [MFW-1:0] ctrl_base;
    logic [1:0]     ctrl_crc_e;
    logic [MFW-1:0] sw_limit;
    logic           sw_limit_we;
    logic           err_clr;
    logic [MFW-1:0] hw_submit;
    logic [MFW-1:0] hw_done;
    logic [2:0]     inflight;
    logic           busy;
    logic           done_stb;
    logic           err_seq;
    logic           err_lim;
    logic           starve;

    int n_chk  = 0;
    int n_fail = 0;

    e1_tx_bd_sched_if #(.MFW(MFW)) bif ();

    e1_tx_bd_sched #(.MFW(MFW), .MAX_INFLIGHT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_ctrl_enable (ctrl_enable),
        .i_ctrl_base   (ctrl_base),
        .i_ctrl_crc_e  (ctrl_crc_e),
        .i_sw_limit    (sw_limit),
        .i_sw_limit_we (sw_limit_we),
        .i_err_clr     (err_clr),
        .bd            (bif),
        .o_hw_submit   (hw_submit),
        .o_hw_done     (hw_done),
        .o_inflight    (inflight),
        .o_busy        (busy),
        .o_done_stb    (done_stb),
        .o_err_seq     (err_seq),
        .o_err_lim     (err_lim),
        .o_starve      (starve)
    );

    always #5 clk = ~clk;

    // Cycle counter used to measure write spacing
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // BD-Out FIFO model: bench pushes, DUT pops on bto_rden
    logic [MFW-1:0] bto_mem [32];
    int bto_wp = 0;
    int bto_rp = 0;
    assign bif.bto_empty = (bto_wp == bto_rp);
    assign bif.bto_data  = bto_mem[5'(bto_rp)];
    always @(posedge clk) if (bif.bto_rden && (bto_rp != bto_wp)) bto_rp <= bto_rp + 1;

    // BD-In write recorder and done-strobe counter
    logic [MFW+1:0] bti_log [32];
    int bti_cyc [32];
    int bti_cnt = 0;
    int stb_cnt = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (bif.bti_wren) begin
                bti_log[5'(bti_cnt)] <= bif.bti_data;
                bti_cyc[5'(bti_cnt)] <= cyc;
                bti_cnt <= bti_cnt + 1;
            end
            if (done_stb) stb_cnt <= stb_cnt + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [MFW-1:0] v);
        bto_mem[5'(bto_wp)] = v;
        bto_wp = bto_wp + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        ctrl_enable = 1'b0;
        ctrl_base = '0;
        ctrl_crc_e = '0;
        sw_limit = '0;
        sw_limit_we = 1'b0;
        err_clr = 1'b0;
        bif.bti_full = 1'b0;

        // Reset values
        tick(3);
        chk("rst_submit",   32'(hw_submit), 32'd0);
        chk("rst_done",     32'(hw_done), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        chk("rst_busy",     32'(busy), 32'd0);
        chk("rst_wren",     32'(bif.bti_wren), 32'd0);
        chk("rst_starve",   32'(starve), 32'd0);
        rst = 1'b0;
        tick(2);

        // 1: base 5, limit 9 -> BDs 5..8 then stop at inflight 4
        ctrl_crc_e = 2'b10; ctrl_base = 7'd5; sw_limit = 7'd9; sw_limit_we = 1'b1; ctrl_enable = 1'b1;
        tick(1);
        sw_limit_we = 1'b0;
        tick(20);
        chk("t1_cnt",      32'(bti_cnt), 32'd4);
        chk("t1_bd0",      32'(bti_log[0]), 32'h105);
        chk("t1_bd1",      32'(bti_log[1]), 32'h106);
        chk("t1_bd3",      32'(bti_log[3]), 32'h108);
        chk("t1_spacing",  32'(bti_cyc[1] - bti_cyc[0]), 32'd2);
        chk("t1_submit",   32'(hw_submit), 32'd9);
        chk("t1_inflight", 32'(inflight), 32'd4);
        chk("t1_busy",     32'(busy), 32'd1);

        // 2: full held while all four complete; release resumes at 9
        bif.bti_full = 1'b1; sw_limit = 7'd20; sw_limit_we = 1'b1;
        push(7'd5); push(7'd6); push(7'd7); push(7'd8);
        tick(1);
        sw_limit_we = 1'b0;
        tick(20);
        chk("t2_full_cnt", 32'(bti_cnt), 32'd4);
        chk("t2_done",     32'(hw_done), 32'd9);
        chk("t2_inflight", 32'(inflight), 32'd0);
        chk("t2_stb",      32'(stb_cnt), 32'd4);
        chk("t2_errseq",   32'(err_seq), 32'd0);
        chk("t2_errlim",   32'(err_lim), 32'd0);
        chk("t2_starve",   32'(starve), 32'd0);
        bif.bti_full = 1'b0;
        tick(12);
        chk("t2_cnt",      32'(bti_cnt), 32'd8);
        chk("t2_bd4",      32'(bti_log[4]), 32'h109);
        chk("t2_bd7",      32'(bti_log[7]), 32'h10C);
        chk("t2_spacing",  32'(bti_cyc[5] - bti_cyc[4]), 32'd2);
        chk("t2_submit",   32'(hw_submit), 32'd13);

        // 6b: limit written behind hw_submit while inflight is capped
        sw_limit = 7'd11; sw_limit_we = 1'b1;
        tick(1);
        sw_limit_we = 1'b0;
        tick(1);
        chk("t6_errlim_set", 32'(err_lim), 32'd1);
        sw_limit = 7'd13; sw_limit_we = 1'b1;
        tick(1);
        sw_limit_we = 1'b0; err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(1);
        chk("t6_errlim_clr", 32'(err_lim), 32'd0);

        // 4: completion 11 while hw_done=10 -> err_seq, resync to 12
        push(7'd9); push(7'd11);
        tick(8);
        chk("t4_done",     32'(hw_done), 32'd12);
        chk("t4_errseq",   32'(err_seq), 32'd1);
        chk("t4_inflight", 32'(inflight), 32'd2);
        push(7'd12);
        tick(6);
        chk("t4_done2",    32'(hw_done), 32'd13);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(1);
        chk("t4_errclr",   32'(err_seq), 32'd0);
        chk("t4_nostarve", 32'(starve), 32'd0);
        chk("t4_cnt",      32'(bti_cnt), 32'd8);

        // 6a: stale completion drains inflight to 0 with submit==limit -> starve
        push(7'd12);
        tick(6);
        chk("t6_errseq",   32'(err_seq), 32'd1);
        chk("t6_inflight", 32'(inflight), 32'd0);
        chk("t6_starve",   32'(starve), 32'd1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(1);
        chk("t6_starve_wins", 32'(starve), 32'd1);
        chk("t6_errseq_clr",  32'(err_seq), 32'd0);

        // 5: three in flight, drop enable -> DRAIN, no submits even with room
        sw_limit = 7'd16; sw_limit_we = 1'b1;
        tick(1);
        sw_limit_we = 1'b0;
        tick(10);
        chk("t5_cnt",      32'(bti_cnt), 32'd11);
        chk("t5_bd10",     32'(bti_log[10]), 32'h10F);
        chk("t5_inflight", 32'(inflight), 32'd3);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("t5_starve_clr", 32'(starve), 32'd0);
        ctrl_enable = 1'b0;
        tick(2);
        chk("t5_busy_drain", 32'(busy), 32'd1);
        sw_limit = 7'd30; sw_limit_we = 1'b1;
        tick(1);
        sw_limit_we = 1'b0;
        tick(10);
        chk("t5_no_submit", 32'(bti_cnt), 32'd11);
        chk("t5_still_busy", 32'(busy), 32'd1);
        push(7'd13); push(7'd14); push(7'd15);
        tick(12);
        chk("t5_done",     32'(hw_done), 32'd16);
        chk("t5_inflight0", 32'(inflight), 32'd0);
        chk("t5_idle",     32'(busy), 32'd0);
        chk("t5_stb",      32'(stb_cnt), 32'd11);

        // 3: wrap across the 128-entry ring
        ctrl_crc_e = 2'b01; ctrl_base = 7'd126; sw_limit = 7'd2; sw_limit_we = 1'b1; ctrl_enable = 1'b1;
        tick(1);
        sw_limit_we = 1'b0;
        tick(12);
        chk("t3_cnt",      32'(bti_cnt), 32'd15);
        chk("t3_bd126",    32'(bti_log[11]), 32'h0FE);
        chk("t3_bd127",    32'(bti_log[12]), 32'h0FF);
        chk("t3_bd0",      32'(bti_log[13]), 32'h080);
        chk("t3_bd1",      32'(bti_log[14]), 32'h081);
        chk("t3_submit",   32'(hw_submit), 32'd2);
        chk("t3_inflight", 32'(inflight), 32'd4);
        push(7'd126); push(7'd127); push(7'd0); push(7'd1);
        tick(12);
        chk("t3_done",     32'(hw_done), 32'd2);
        chk("t3_inflight0", 32'(inflight), 32'd0);
        chk("t3_errseq",   32'(err_seq), 32'd0);
        chk("t3_errlim",   32'(err_lim), 32'd0);
        chk("t3_starve",   32'(starve), 32'd1);

        // Asynchronous reset mid-operation
        ctrl_enable = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("arst_busy",   32'(busy), 32'd0);
        chk("arst_submit", 32'(hw_submit), 32'd0);
        chk("arst_done",   32'(hw_done), 32'd0);
        chk("arst_starve", 32'(starve), 32'd0);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
